// File: rtl/arm_core_pkg.sv
// Shared types, encodings and field helpers for the multi-cycle ARM core.
// ARM_CORE_ROTIMM_EN selects the rotated-immediate operand form in f_imm.
package arm_core_pkg;

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

    localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                           OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                           OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                           OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

    localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
                           CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
                           CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
                           CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE;

    localparam logic [1:0] IT_DP = 2'b00;
    localparam logic [2:0] IT_BR = 3'b101;

    localparam int FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;

    function automatic logic [3:0] f_cond(input logic [31:0] i);   return i[31:28]; endfunction
    function automatic logic [3:0] f_opcode(input logic [31:0] i); return i[24:21]; endfunction
    function automatic logic [3:0] f_rn(input logic [31:0] i);     return i[19:16]; endfunction
    function automatic logic [3:0] f_rd(input logic [31:0] i);     return i[15:12]; endfunction
    function automatic logic [3:0] f_rm(input logic [31:0] i);     return i[3:0];   endfunction

    function automatic logic [31:0] f_boff(input logic [31:0] i);
        return {{6{i[23]}}, i[23:0], 2'b00};
    endfunction

    function automatic logic [31:0] f_imm(input logic [31:0] i);
`ifdef ARM_CORE_ROTIMM_EN
        logic [63:0] dbl;
        dbl = {2{{24'b0, i[7:0]}}} >> {i[11:8], 1'b0};
        return dbl[31:0];
`else
        return {24'b0, i[7:0]};
`endif
    endfunction

    // Arithmetic ops own C and V; logical ops leave them to the shifter/old flags.
    function automatic logic f_is_arith(input logic [3:0] op);
        return (op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN});
    endfunction

    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            CC_EQ: return z;
            CC_NE: return !z;
            CC_CS: return c;
            CC_CC: return !c;
            CC_MI: return n;
            CC_PL: return !n;
            CC_VS: return v;
            CC_VC: return !v;
            CC_HI: return c && !z;
            CC_LS: return !c || z;
            CC_GE: return n == v;
            CC_LT: return n != v;
            CC_GT: return !z && (n == v);
            CC_LE: return z || (n != v);
            CC_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_alu.sv
// Combinational data-processing ALU: all 16 ARM opcodes, flags out.
module arm_alu
    import arm_core_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        n,
    output logic        z,
    output logic        c,
    output logic        v,
    output logic        writes_rd
);
    logic [31:0] x, y, lres;
    logic        cin;
    logic [32:0] sum;

    // Every arithmetic op is folded onto one adder: x + y + cin.
    always_comb begin
        x    = a;
        y    = b;
        cin  = 1'b0;
        lres = 32'h0;
        case (opcode)
            OP_AND, OP_TST: lres = a & b;
            OP_EOR, OP_TEQ: lres = a ^ b;
            OP_SUB, OP_CMP: begin y = ~b; cin = 1'b1; end
            OP_RSB:         begin x = b; y = ~a; cin = 1'b1; end
            OP_ADD, OP_CMN: cin = 1'b0;
            OP_ADC:         cin = carry_in;
            OP_SBC:         begin y = ~b; cin = carry_in; end
            OP_RSC:         begin x = b; y = ~a; cin = carry_in; end
            OP_ORR:         lres = a | b;
            OP_MOV:         lres = b;
            OP_BIC:         lres = a & ~b;
            default:        lres = ~b;
        endcase
    end

    assign sum       = {1'b0, x} + {1'b0, y} + {32'b0, cin};
    assign result    = f_is_arith(opcode) ? sum[31:0] : lres;
    assign n         = result[31];
    assign z         = (result == 32'h0);
    assign c         = f_is_arith(opcode) ? sum[32] : carry_in;
    assign v         = f_is_arith(opcode) && (x[31] == y[31]) && (sum[31] != x[31]);
    assign writes_rd = (opcode[3:2] != 2'b10);

endmodule

// File: rtl/arm_core_mc.sv
// Multi-cycle ARM subset core: FETCH -> DECODE -> EXEC, HALT on unsupported types.
// ARM_CORE_ROTIMM_EN enables rotated immediates and their shifter carry-out.
module arm_core_mc
    import arm_core_pkg::*;
#(
    parameter int          CODE_ADDR_W = 8,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                   clk,
    input  logic                   nreset,
    output logic                   imem_req,
    output logic [CODE_ADDR_W-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic                   halted,
    output logic                   led,
    output logic [7:0]             debug_port1,
    output logic [7:0]             debug_port2,
    output logic [7:0]             debug_port3
);
    state_t      state, state_nxt;
    logic [31:0] pc, ir, pc_nxt;
    logic [3:0]  cpsr, flags_nxt;
    logic        run, halted_q;
    logic [31:0] rf [0:14];
    logic [31:0] a_q, b_q, rn_data, rm_data, op2;
    logic        cond_q, immc_q, immc_en_q, immc_en_d;
    logic [31:0] alu_res;
    logic        alu_n, alu_z, alu_c, alu_v, alu_wr;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;

    // r15 reads see the pipeline-visible pc+8.
    assign rn_data = (f_rn(ir) == 4'd15) ? pc + 32'd8 : rf[f_rn(ir)];
    assign rm_data = (f_rm(ir) == 4'd15) ? pc + 32'd8 : rf[f_rm(ir)];
    assign op2     = ir[25] ? f_imm(ir) : rm_data;
`ifdef ARM_CORE_ROTIMM_EN
    assign immc_en_d = ir[25] && (ir[11:8] != 4'd0);
`else
    assign immc_en_d = 1'b0;
`endif

    arm_alu u_alu (
        .opcode   (f_opcode(ir)),
        .a        (a_q),
        .b        (b_q),
        .carry_in (cpsr[FLAG_C]),
        .result   (alu_res),
        .n        (alu_n),
        .z        (alu_z),
        .c        (alu_c),
        .v        (alu_v),
        .writes_rd(alu_wr)
    );

    assign imem_req    = run && (state == S_FETCH);
    assign imem_addr   = pc[CODE_ADDR_W+1:2];
    assign halted      = halted_q;
    assign led         = pc[2];
    assign debug_port1 = pc[9:2];
    assign debug_port2 = ir[7:0];
    assign debug_port3 = rn_data[7:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (imem_req && imem_ack) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = ir[26] ? S_HALT : S_FETCH;
            default:  state_nxt = S_HALT;
        endcase
    end

    // Commit decision for the EXEC cycle; a failed condition just steps pc.
    always_comb begin
        pc_nxt    = pc + 32'd4;
        flags_nxt = cpsr;
        rf_we     = 1'b0;
        rf_wa     = f_rd(ir);
        rf_wd     = alu_res;
        if (cond_q) begin
            if (ir[27:26] == IT_DP) begin
                if (alu_wr) begin
                    if (f_rd(ir) == 4'd15) pc_nxt = {alu_res[31:2], 2'b00};
                    else                   rf_we  = 1'b1;
                end
                if (ir[20] || !alu_wr) begin
                    flags_nxt[FLAG_N] = alu_n;
                    flags_nxt[FLAG_Z] = alu_z;
                    if (f_is_arith(f_opcode(ir))) begin
                        flags_nxt[FLAG_C] = alu_c;
                        flags_nxt[FLAG_V] = alu_v;
                    end else if (immc_en_q) begin
                        flags_nxt[FLAG_C] = immc_q;
                    end
                end
            end else if (ir[27:25] == IT_BR) begin
                pc_nxt = pc + 32'd8 + f_boff(ir);
                if (ir[24]) begin
                    rf_we = 1'b1;
                    rf_wa = 4'd14;
                    rf_wd = pc + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= 32'h0;
            cpsr      <= 4'h0;
            halted_q  <= 1'b0;
            run       <= 1'b0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            cond_q    <= 1'b0;
            immc_q    <= 1'b0;
            immc_en_q <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            case (state)
                S_FETCH: if (imem_req && imem_ack) ir <= imem_rdata;
                S_DECODE: begin
                    a_q       <= rn_data;
                    b_q       <= op2;
                    cond_q    <= cond_pass(f_cond(ir), cpsr);
                    immc_q    <= op2[31];
                    immc_en_q <= immc_en_d;
                end
                S_EXEC: begin
                    if (ir[26]) begin
                        halted_q <= 1'b1;
                    end else begin
                        pc   <= pc_nxt;
                        cpsr <= flags_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Architectural registers are not reset; writes only happen out of EXEC.
    always_ff @(posedge clk) begin
        if (nreset && state == S_EXEC && !ir[26] && rf_we && rf_wa != 4'd15)
            rf[rf_wa] <= rf_wd;
    end

endmodule

// File: tb/tb_arm_core_mc.sv
// Directed bench for arm_core_mc: small programs with hand-computed results.
module tb_arm_core_mc;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        imem_req, imem_ack, halted, led;
    logic [7:0]  imem_addr, debug_port1, debug_port2, debug_port3;
    logic [31:0] imem_rdata;
    logic [31:0] mem [0:255];
    int          checks = 0, errors = 0, wait_states = 0, wcnt = 0;

    arm_core_mc #(.CODE_ADDR_W(8), .RESET_PC(32'h0)) dut (
        .clk(clk), .nreset(nreset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .halted(halted), .led(led),
        .debug_port1(debug_port1), .debug_port2(debug_port2), .debug_port3(debug_port3)
    );

    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr];

    // Memory responder: ack after wait_states idle request cycles.
    initial begin
        imem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (wcnt >= wait_states) begin imem_ack = 1'b1; wcnt = 0; end
                else begin imem_ack = 1'b0; wcnt++; end
            end else begin
                imem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'hE1A0_0000;
    endtask

    // Holds reset for two cycles, then releases it on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("rst_pc", dut.pc, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_cpsr", {28'b0, dut.cpsr}, 32'h0);
        nreset = 1'b1;
        #1;
        chk("rel_req_low", {31'b0, imem_req}, 32'h0);
    endtask

    initial begin
        // Counter loop: r2 += r1 at 0x8, branch back from 0xC.
        clear_mem();
        mem[0] = 32'hE3A0_1001; mem[1] = 32'hE3A0_2000;
        mem[2] = 32'hE082_2001; mem[3] = 32'hEAFF_FFFD;
        do_reset();
        step(1);
        chk("first_req", {31'b0, imem_req}, 32'h1);
        step(6);
        chk("loop_r1", dut.rf[1], 32'h1);
        chk("loop_r2_init", dut.rf[2], 32'h0);
        step(3);
        chk("loop_r2_1", dut.rf[2], 32'h1);
        chk("loop_pc_c", dut.pc, 32'hC);
        step(3);
        chk("loop_pc_8", dut.pc, 32'h8);
        chk("loop_addr", {24'b0, imem_addr}, 32'h2);
        chk("loop_req", {31'b0, imem_req}, 32'h1);
        step(3);
        chk("loop_r2_2", dut.rf[2], 32'h2);
        step(6);
        chk("loop_r2_3", dut.rf[2], 32'h3);

        // SUBS underflow then BEQ not taken.
        clear_mem();
        mem[0] = 32'hE3A0_0000; mem[1] = 32'hE250_0001; mem[2] = 32'h0A00_0000;
        do_reset();
        step(7);
        chk("subs_r0", dut.rf[0], 32'hFFFF_FFFF);
        chk("subs_nzcv", {28'b0, dut.cpsr}, 32'h8);
        step(3);
        chk("beq_pc", dut.pc, 32'hC);

        // Branch to 0x20, then BL to 0x100 fetched with two wait states.
        clear_mem();
        mem[0] = 32'hEA00_0006; mem[8] = 32'hEB00_0036;
        do_reset();
        step(4);
        chk("b_pc", dut.pc, 32'h20);
        wait_states = 2;
        step(1);
        chk("bl_wait_addr1", {24'b0, imem_addr}, 32'h8);
        chk("bl_wait_req1", {31'b0, imem_req}, 32'h1);
        step(1);
        chk("bl_wait_addr2", {24'b0, imem_addr}, 32'h8);
        step(2);
        chk("bl_pc_4cyc", dut.pc, 32'h20);
        step(1);
        chk("bl_pc_5cyc", dut.pc, 32'h100);
        chk("bl_lr", dut.rf[14], 32'h24);
        wait_states = 0;

        // Unsupported type-01 instruction at 0x40 halts the core.
        clear_mem();
        mem[0] = 32'hEA00_000E; mem[16] = 32'hE600_0000;
        do_reset();
        step(8);
        chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("halt_req", {31'b0, imem_req}, 32'h0);
        chk("halt_pc", dut.pc, 32'h40);
        chk("halt_dbg1", {24'b0, debug_port1}, 32'h10);
        step(5);
        chk("halt_pc_frozen", dut.pc, 32'h40);
        chk("halt_sticky", {31'b0, halted}, 32'h1);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("halt_rst_pc", dut.pc, 32'h0);
        chk("halt_rst_flag", {31'b0, halted}, 32'h0);
        @(negedge clk);
        nreset = 1'b1;

        // Rotated immediate: MOV r3,#0xFF ror 8 and MOVS r4 of the same.
        clear_mem();
        mem[0] = 32'hE3A0_34FF; mem[1] = 32'hE3B0_44FF;
        do_reset();
        step(4);
        chk("ir_dbg2", {24'b0, debug_port2}, 32'hFF);
`ifdef ARM_CORE_ROTIMM_EN
        chk("rot_r3", dut.rf[3], 32'hFF00_0000);
        step(3);
        chk("rot_r4", dut.rf[4], 32'hFF00_0000);
        chk("rot_nzcv", {28'b0, dut.cpsr}, 32'hA);
`else
        chk("rot_r3", dut.rf[3], 32'h0000_00FF);
        step(3);
        chk("rot_r4", dut.rf[4], 32'h0000_00FF);
        chk("rot_nzcv", {28'b0, dut.cpsr}, 32'h0);
`endif

        // ALU mix, condition failure, r15 read and MOV pc.
        clear_mem();
        mem[0] = 32'hE3A0_500F; mem[1] = 32'hE3E0_6000; mem[2] = 32'hE096_7005;
        mem[3] = 32'hE0A5_8005; mem[4] = 32'hE355_000F; mem[5] = 32'h13A0_5001;
        mem[6] = 32'hE025_A006; mem[7] = 32'hE2C5_B001; mem[8] = 32'hE28F_C000;
        mem[9] = 32'hE3A0_F013;
        do_reset();
        step(10);
        chk("adds_r7", dut.rf[7], 32'hE);
        chk("adds_nzcv", {28'b0, dut.cpsr}, 32'h2);
        step(3);
        chk("adc_r8", dut.rf[8], 32'h1F);
        step(3);
        chk("cmp_nzcv", {28'b0, dut.cpsr}, 32'h6);
        step(3);
        chk("movne_skip_r5", dut.rf[5], 32'hF);
        chk("movne_pc", dut.pc, 32'h18);
        step(3);
        chk("eor_r10", dut.rf[10], 32'hFFFF_FFF0);
        step(3);
        chk("sbc_r11", dut.rf[11], 32'hE);
        step(3);
        chk("pc_read_r12", dut.rf[12], 32'h28);
        step(3);
        chk("mov_pc", dut.pc, 32'h10);
        chk("mov_pc_led", {31'b0, led}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
